// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: operation codes and FSM states.
package alu_pkg;

    typedef enum logic [4:0] {
        OP_XNOR = 5'h00,
        OP_XOR  = 5'h02,
        OP_NAND = 5'h04,
        OP_NOR  = 5'h06,
        OP_AND  = 5'h08,
        OP_SRL  = 5'h09,
        OP_OR   = 5'h0A,
        OP_ADD  = 5'h0C,
        OP_SLL  = 5'h0D,
        OP_SRA  = 5'h0F,
        OP_MUL  = 5'h10,
        OP_DIVU = 5'h11,
        OP_SUB  = 5'h1C,
        OP_SLT  = 5'h1E
    } alu_op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } alu_state_t;

endpackage

// File: rtl/mc_alu_if.sv
// Operand and result handshake bundle between register-file read and writeback.
interface mc_alu_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [4:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] y_hi;
    logic             carry;
    logic             zero;
    logic             neg;
    logic             ovf;
    logic             div_by_zero;

    // Producer of operands and consumer of results
    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, y, y_hi, carry, zero, neg, ovf, div_by_zero
    );

    // The ALU itself
    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, y, y_hi, carry, zero, neg, ovf, div_by_zero
    );
endinterface

// File: rtl/mc_alu_core.sv
// Single-cycle ALU operations: logic, add/sub, SLT and shifts. Returns zero
// (and no carry/overflow) for MUL, DIVU and unassigned codes.
module mc_alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [4:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] y_o,
    output logic             carry_o,
    output logic             ovf_o
);
    localparam int SHW = $clog2(WIDTH);

    logic [WIDTH-1:0]        b_eff;
    logic [WIDTH:0]          sum;
    logic                    add_ovf;
    logic [SHW-1:0]          shamt;
    logic signed [WIDTH-1:0] b_s;
    logic signed [WIDTH-1:0] sra_s;

    // op[4] turns the adder into a subtractor: invert b, carry-in of one
    assign b_eff   = op_i[4] ? ~b_i : b_i;
    assign sum     = {1'b0, a_i} + {1'b0, b_eff} + {{WIDTH{1'b0}}, op_i[4]};
    assign add_ovf = (a_i[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);
    assign shamt   = a_i[SHW-1:0];
    assign b_s     = $signed(b_i);
    assign sra_s   = b_s >>> shamt;

    // Operation select with all outputs defaulted to zero
    always_comb begin
        y_o     = '0;
        carry_o = 1'b0;
        ovf_o   = 1'b0;
        case (op_i)
            OP_AND:  y_o = a_i & b_i;
            OP_OR:   y_o = a_i | b_i;
            OP_NAND: y_o = ~(a_i & b_i);
            OP_NOR:  y_o = ~(a_i | b_i);
            OP_XNOR: y_o = ~(a_i ^ b_i);
            OP_XOR:  y_o = a_i ^ b_i;
            OP_ADD, OP_SUB: begin
                y_o     = sum[WIDTH-1:0];
                carry_o = sum[WIDTH];
                ovf_o   = add_ovf;
            end
            OP_SLT: begin
                y_o     = {{(WIDTH-1){1'b0}}, sum[WIDTH-1]};
                carry_o = sum[WIDTH];
            end
            OP_SLL:  y_o = b_i << shamt;
            OP_SRL:  y_o = b_i >> shamt;
            OP_SRA:  y_o = $unsigned(sra_s);
            default: y_o = '0;
        endcase
    end
endmodule

// File: rtl/mc_alu.sv
// Multi-cycle ALU: handshake FSM, iterative shift-add multiply and restoring
// divide, registered results and flags.
module mc_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    mc_alu_if.slave     bus
);
    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW:0] CNT_LAST = (SHW+1)'(WIDTH - 1);

    alu_state_t       state_q, state_d;
    logic [SHW:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0] y_q, y_d, yhi_q, yhi_d;
    logic             carry_q, carry_d, zero_q, zero_d, neg_q, neg_d;
    logic             ovf_q, ovf_d, dbz_q, dbz_d;

    // Iteration working registers; meaningless outside MUL/DIV, so not reset
    logic [WIDTH-1:0] opnd_q, opnd_d, hi_q, hi_d, lo_q, lo_d;

    logic [WIDTH-1:0] core_y;
    logic             core_carry, core_ovf;
    logic [WIDTH-1:0] mul_add;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_diff;

    logic             load;
    logic [WIDTH-1:0] res_y, res_hi;
    logic             res_carry, res_ovf, res_dbz;

    mc_alu_core #(.WIDTH(WIDTH)) u_core (
        .op_i    (bus.op),
        .a_i     (bus.a),
        .b_i     (bus.b),
        .y_o     (core_y),
        .carry_o (core_carry),
        .ovf_o   (core_ovf)
    );

    // One shift-add step: conditionally add multiplicand to the high half
    assign mul_add   = lo_q[0] ? opnd_q : {WIDTH{1'b0}};
    assign mul_sum   = {1'b0, hi_q} + {1'b0, mul_add};
    // One restoring-divide step: shift in the next dividend bit and trial-subtract
    assign div_shift = {hi_q, lo_q[WIDTH-1]};
    assign div_ge    = (div_shift >= {1'b0, opnd_q});
    assign div_diff  = div_shift[WIDTH-1:0] - opnd_q;

    // Next-state, iteration and result-capture logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        opnd_d    = opnd_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        y_d       = y_q;
        yhi_d     = yhi_q;
        carry_d   = carry_q;
        zero_d    = zero_q;
        neg_d     = neg_q;
        ovf_d     = ovf_q;
        dbz_d     = dbz_q;
        load      = 1'b0;
        res_y     = '0;
        res_hi    = '0;
        res_carry = 1'b0;
        res_ovf   = 1'b0;
        res_dbz   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    cnt_d = '0;
                    if (bus.op == OP_MUL) begin
                        opnd_d  = bus.a;
                        hi_d    = '0;
                        lo_d    = bus.b;
                        state_d = S_MUL;
                    end else if (bus.op == OP_DIVU && bus.b != '0) begin
                        opnd_d  = bus.b;
                        hi_d    = '0;
                        lo_d    = bus.a;
                        state_d = S_DIV;
                    end else if (bus.op == OP_DIVU) begin
                        load    = 1'b1;
                        res_y   = '1;
                        res_hi  = bus.a;
                        res_dbz = 1'b1;
                    end else begin
                        load      = 1'b1;
                        res_y     = core_y;
                        res_carry = core_carry;
                        res_ovf   = core_ovf;
                    end
                end
            end
            S_MUL: begin
                hi_d  = mul_sum[WIDTH:1];
                lo_d  = {mul_sum[0], lo_q[WIDTH-1:1]};
                cnt_d = cnt_q + (SHW+1)'(1);
                if (cnt_q == CNT_LAST) begin
                    load    = 1'b1;
                    res_y   = {mul_sum[0], lo_q[WIDTH-1:1]};
                    res_hi  = mul_sum[WIDTH:1];
                    res_ovf = (mul_sum[WIDTH:1] != '0);
                end
            end
            S_DIV: begin
                hi_d  = div_ge ? div_diff : div_shift[WIDTH-1:0];
                lo_d  = {lo_q[WIDTH-2:0], div_ge};
                cnt_d = cnt_q + (SHW+1)'(1);
                if (cnt_q == CNT_LAST) begin
                    load   = 1'b1;
                    res_y  = {lo_q[WIDTH-2:0], div_ge};
                    res_hi = div_ge ? div_diff : div_shift[WIDTH-1:0];
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (load) begin
            state_d = S_DONE;
            y_d     = res_y;
            yhi_d   = res_hi;
            carry_d = res_carry;
            ovf_d   = res_ovf;
            dbz_d   = res_dbz;
            zero_d  = (res_y == '0);
            neg_d   = res_y[WIDTH-1];
        end
    end

    // FSM state, counter and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            y_q     <= '0;
            yhi_q   <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
            ovf_q   <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            yhi_q   <= yhi_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
            neg_q   <= neg_d;
            ovf_q   <= ovf_d;
            dbz_q   <= dbz_d;
        end
    end

    // Multiply/divide working registers
    always_ff @(posedge clk) begin
        opnd_q <= opnd_d;
        hi_q   <= hi_d;
        lo_q   <= lo_d;
    end

    assign bus.in_ready    = (state_q == S_IDLE);
    assign bus.out_valid   = (state_q == S_DONE);
    assign bus.y           = y_q;
    assign bus.y_hi        = yhi_q;
    assign bus.carry       = carry_q;
    assign bus.zero        = zero_q;
    assign bus.neg         = neg_q;
    assign bus.ovf         = ovf_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_mc_alu.sv
// Directed bench for mc_alu with hand-computed expected results.
module tb_mc_alu;
    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    mc_alu_if #(.WIDTH(16)) bus ();

    mc_alu #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Flag vector order: carry, zero, neg, ovf, div_by_zero
    function automatic logic [4:0] flags();
        return {bus.carry, bus.zero, bus.neg, bus.ovf, bus.div_by_zero};
    endfunction

    // Present one op, wait for the result; lat = cycles from accept edge (0 = timeout)
    task automatic issue(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                         output int lat, output logic busy_rdy);
        busy_rdy = 1'b0;
        bus.op = op;
        bus.a = a;
        bus.b = b;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                lat = i;
                break;
            end
            if (bus.in_ready) busy_rdy = 1'b1;
            @(posedge clk);
            #1;
        end
    endtask

    // Consume the current result
    task automatic take();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
    endtask

    // One full directed vector
    task automatic vec(input string tag, input logic [4:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic [15:0] ey, input logic [15:0] ehi,
                       input logic [4:0] efl, input int elat);
        int   lat;
        logic busy_rdy;
        chk({tag, "_rdy"}, bus.in_ready, 1);
        issue(op, a, b, lat, busy_rdy);
        chk({tag, "_lat"}, lat, elat);
        chk({tag, "_y"}, bus.y, ey);
        chk({tag, "_yhi"}, bus.y_hi, ehi);
        chk({tag, "_flags"}, flags(), efl);
        if (elat > 1) chk({tag, "_busy"}, busy_rdy, 0);
        take();
    endtask

    initial begin
        int   lat;
        logic busy_rdy;
        logic [15:0] hold_y;
        n_tests = 0;
        n_fail = 0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.op = 5'h0;
        bus.a = '0;
        bus.b = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_y", bus.y, 0);
        chk("rst_yhi", bus.y_hi, 0);
        chk("rst_flags", flags(), 0);

        vec("add",   5'h0C, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 5'b11000, 1);
        vec("sub",   5'h1C, 16'h8000, 16'h0001, 16'h7FFF, 16'h0000, 5'b10010, 1);
        vec("slt",   5'h1E, 16'hFFFE, 16'h0001, 16'h0001, 16'h0000, 5'b10000, 1);
        vec("sra",   5'h0F, 16'h0004, 16'h8000, 16'hF800, 16'h0000, 5'b00100, 1);
        vec("sll",   5'h0D, 16'h0013, 16'h0001, 16'h0008, 16'h0000, 5'b00000, 1);
        vec("srl",   5'h09, 16'h0004, 16'h8000, 16'h0800, 16'h0000, 5'b00000, 1);
        vec("xor",   5'h02, 16'hF0F0, 16'hFF00, 16'h0FF0, 16'h0000, 5'b00000, 1);
        vec("nand",  5'h04, 16'hF0F0, 16'hFF00, 16'h0FFF, 16'h0000, 5'b00000, 1);
        vec("badop", 5'h1F, 16'h0005, 16'h0003, 16'h0000, 16'h0000, 5'b01000, 1);
        vec("mul",   5'h10, 16'h1234, 16'h0100, 16'h3400, 16'h0012, 5'b00010, 17);
        vec("mulmax",5'h10, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 5'b00010, 17);
        vec("mulsm", 5'h10, 16'h0003, 16'h0005, 16'h000F, 16'h0000, 5'b00000, 17);
        vec("divu",  5'h11, 16'd100,  16'd7,    16'd14,   16'd2,    5'b00000, 17);
        vec("divbig",5'h11, 16'hFFFF, 16'h0010, 16'h0FFF, 16'h000F, 5'b00000, 17);
        vec("div0",  5'h11, 16'h00AB, 16'h0000, 16'hFFFF, 16'h00AB, 5'b00101, 1);

        // Hold a result with out_ready low while new inputs are offered
        issue(5'h0A, 16'h1200, 16'h0034, lat, busy_rdy);
        chk("hold_lat", lat, 1);
        hold_y = bus.y;
        chk("hold_y0", hold_y, 16'h1234);
        bus.op = 5'h0C;
        bus.a = 16'h0001;
        bus.b = 16'h0001;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_y", bus.y, 16'h1234);
            chk("hold_valid", bus.out_valid, 1);
            chk("hold_rdy", bus.in_ready, 0);
            chk("hold_flags", flags(), 5'b00000);
        end
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1 take();
        chk("post_hold_rdy", bus.in_ready, 1);

        // Reset in the middle of a multiply
        bus.op = 5'h10;
        bus.a = 16'h1234;
        bus.b = 16'h0100;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("mrst_valid", bus.out_valid, 0);
        chk("mrst_y", bus.y, 0);
        chk("mrst_yhi", bus.y_hi, 0);
        chk("mrst_flags", flags(), 0);
        chk("mrst_rdy", bus.in_ready, 1);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("mrst_idle_valid", bus.out_valid, 0);
        vec("add2", 5'h0C, 16'h0002, 16'h0003, 16'h0005, 16'h0000, 5'b00000, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
